// File: rtl/stream_packer_if.sv
// AXI-stream style bus for the packer: data, byte keep mask, valid/last and ready.
// master drives the payload and slave drives ready.
interface stream_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8
);
    localparam int BYTES = DATA_WIDTH * NUM_DATA / 8;

    logic [DATA_WIDTH*NUM_DATA-1:0] data;
    logic [BYTES-1:0]               tkeep;
    logic                           tvalid;
    logic                           tlast;
    logic                           tready;

    modport master (output data, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input data, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_packer.sv
// Repacks sparse keep-flagged beats into dense beats, preserving packet boundaries.
// A residual buffer carries leftover bytes; FLUSH drains the tail of an overflowing packet.
module stream_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8
) (
    input  logic             clk,
    input  logic             reset,
    stream_packer_if.slave   src,
    stream_packer_if.master  dst
);
    localparam int W    = DATA_WIDTH * NUM_DATA;
    localparam int B    = W / 8;
    localparam int RW   = $clog2(B);
    localparam int CW   = RW + 1;
    localparam int RESW = W - 8;
    localparam logic [CW-1:0] B_C = CW'(B);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    function automatic logic [CW-1:0] popcount(input logic [B-1:0] keep);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < B; i++) cnt = cnt + CW'(keep[i]);
        return cnt;
    endfunction

    function automatic logic [B-1:0] byte_mask(input logic [CW-1:0] k);
        logic [B-1:0] m;
        for (int i = 0; i < B; i++) m[i] = (CW'(i) < k);
        return m;
    endfunction

    function automatic logic [W-1:0] apply_keep(input logic [W-1:0] d, input logic [B-1:0] keep);
        logic [W-1:0] o;
        for (int i = 0; i < B; i++) o[8*i +: 8] = keep[i] ? d[8*i +: 8] : 8'h00;
        return o;
    endfunction

    logic [0:0]      state_p1, state_nxt;
    logic [RESW-1:0] res_p1, res_nxt;
    logic [RW-1:0]   r_p1, r_nxt;
    logic [W-1:0]    data_p1, data_nxt;
    logic [B-1:0]    keep_p1, keep_nxt;
    logic            last_p1, last_nxt;
    logic            vld_p1;
    logic            emit;
    logic            out_free;
    logic            accept;
    logic [CW-1:0]   n_p0, total_p0;
    logic [W-1:0]    in_masked_p0;
    logic [2*W-1:0]  cat_p0;

    assign out_free   = !vld_p1 || dst.tready;
    assign src.tready = (state_p1 == RUN) && out_free && reset;
    assign accept     = src.tvalid && src.tready;

    // Stage p0: byte count and concatenation of the new bytes above the residual
    always_comb begin
        n_p0         = popcount(src.tkeep);
        in_masked_p0 = apply_keep(src.data, src.tkeep);
        total_p0     = CW'(r_p1) + n_p0;
        cat_p0       = ({{W{1'b0}}, in_masked_p0} << (8 * r_p1)) | {{(W + 8){1'b0}}, res_p1};
    end

    always_comb begin
        state_nxt = state_p1;
        res_nxt   = res_p1;
        r_nxt     = r_p1;
        emit      = 1'b0;
        data_nxt  = cat_p0[W-1:0];
        keep_nxt  = {B{1'b1}};
        last_nxt  = 1'b0;
        if (state_p1 == FLUSH) begin
            if (out_free) begin
                emit      = 1'b1;
                data_nxt  = {{(W - RESW){1'b0}}, res_p1};
                keep_nxt  = byte_mask(CW'(r_p1));
                last_nxt  = 1'b1;
                r_nxt     = '0;
                res_nxt   = '0;
                state_nxt = RUN;
            end
        end else if (accept) begin
            if (src.tlast && total_p0 <= B_C) begin
                emit     = 1'b1;
                keep_nxt = byte_mask(total_p0);
                last_nxt = 1'b1;
                r_nxt    = '0;
                res_nxt  = '0;
            end else if (total_p0 >= B_C) begin
                // Full beat out; anything past B bytes stays behind, and a last beat
                // with leftovers must be drained by FLUSH before new input.
                emit    = 1'b1;
                res_nxt = cat_p0[W+RESW-1:W];
                r_nxt   = RW'(total_p0 - B_C);
                if (src.tlast) state_nxt = FLUSH;
            end else begin
                res_nxt = cat_p0[RESW-1:0];
                r_nxt   = RW'(total_p0);
            end
        end
    end

    // Stage p1: residual state and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1 <= RUN;
            res_p1   <= '0;
            r_p1     <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            keep_p1  <= '0;
            last_p1  <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            res_p1   <= res_nxt;
            r_p1     <= r_nxt;
            if (out_free) begin
                vld_p1 <= emit;
                if (emit) begin
                    data_p1 <= data_nxt;
                    keep_p1 <= keep_nxt;
                    last_p1 <= last_nxt;
                end
            end
        end
    end

    assign dst.data   = data_p1;
    assign dst.tkeep  = keep_p1;
    assign dst.tvalid = vld_p1;
    assign dst.tlast  = last_p1;
endmodule

// File: doc/stream_packer.md
# stream_packer

Downstream repacking stage for the Compressor. It consumes the Compressor's 256-bit AXI-stream, whose beats carry a variable number of valid bytes flagged by `tkeep`. It concatenates those bytes and re-emits them as densely packed beats: every beat is full except the last beat of a packet. Packet boundaries (`tlast`) are preserved, and bytes from different packets are never merged into one beat.

## Interface
- `DATA_WIDTH`, default 32: lane width in bits.
- `NUM_DATA`, default 8: lanes per beat. The bus is B = DATA_WIDTH*NUM_DATA/8 = 32 bytes.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `data_in` input, 256 bits: Compressor output data. Byte i is `[8i+7:8i]`; byte 0 is first on the wire.
- `tkeep_in` input, 32 bits: valid-byte mask. It is contiguous from bit 0, so n = popcount, with n in 0..32.
- `tvalid_in` input, 1 bit: input beat valid.
- `tlast_in` input, 1 bit: last beat of the packet.
- `tready_out` output, 1 bit: this block is ready to accept an input beat.
- `data_out` output, 256 bits: packed data.
- `tkeep_out` output, 32 bits: packed mask, always of the form 2^k−1.
- `tvalid_out` output, 1 bit: output beat valid.
- `tlast_out` output, 1 bit: last beat of the packet.
- `tready_in` input, 1 bit: downstream is ready.

## Operation
**Internal state**
- Residual buffer `res[247:0]` holds up to 31 bytes at the low byte positions.
- Count `r` (5 bits) holds the number of residual bytes, 0..31.
- State machine has two states: RUN and FLUSH.

**Handshake signals**
- `out_free` = !`tvalid_out` || `tready_in`.
- `tready_out` = (state==RUN) && `out_free` && reset deasserted.
- An input beat is accepted when `tvalid_in` && `tready_out`.

**On accept in RUN, with total = r + n**
- The concatenation is cat = {incoming n bytes, res r bytes}: the incoming bytes occupy byte positions r..r+n−1.
- `tlast_in`=1, total ≤ 32:
  - Emit cat[0..total−1] with `tkeep_out`=(1<<total)−1 and `tlast_out`=1.
  - Set r=0.
  - total=0 emits a beat with `tkeep_out`=0 and `tlast_out`=1, so the boundary is preserved.
- `tlast_in`=1, total > 32:
  - Emit cat[0..31] with `tkeep_out`=FFFFFFFF and `tlast_out`=0.
  - Set res=cat[32..total−1] and r=total−32.
  - Go to FLUSH.
- `tlast_in`=0, total ≥ 32:
  - Emit cat[0..31] with `tlast_out`=0.
  - Set res=cat[32..], r=total−32.
- `tlast_in`=0, total < 32:
  - No emit; set res=cat and r=total.
  - If the old output was being drained (`tready_in`), `tvalid_out` clears.
- An accepted beat with n=0 and `tlast_in`=0 changes nothing.

**FLUSH state**
- Input is stalled.
- When `out_free`: emit res[0..r−1] with `tkeep_out`=(1<<r)−1 and `tlast_out`=1, set r=0, and return to RUN.

**Output register**
- The output is a register stage.
- If `tvalid_out` && !`tready_in`, all of `data_out`, `tkeep_out` and `tlast_out` hold stable.
- If there is no new emit and the output is drained, `tvalid_out` goes to 0.
- Bytes of `data_out` outside `tkeep_out` are driven to 0.

## Timing
**Reset**
- While `reset`=0, all of the following are 0 and the state is RUN:
  - `tvalid_out`, `tlast_out`, `tkeep_out`, `data_out`;
  - `r`, `res`;
  - `tready_out`.
- Reset asserted mid-packet discards the residual and any pending output. The next packet after release starts with r=0.

**Latency and throughput**
- Latency is 1 cycle: `tvalid_out` rises on the edge that accepts the completing input beat.
- Sustained throughput is one beat per cycle in RUN.
- FLUSH inserts exactly one input stall cycle (more if `tready_in` is low) per packet whose final total exceeds 32.

**Boundary conditions**
- r=31 with n=32, non-last: emit 32 bytes, r=31 again.
- Residual never exceeds 31 bytes, because packets are flushed at `tlast` and FLUSH drains before new input.
- A simultaneous drain (`tready_in`) and new emit on the same edge loads the new beat with no bubble.

## Test plan
1. **Merge two half beats.**
   - Stimulus: two beats with `tkeep_in`=0000FFFF, bytes 00..0F then 10..1F; the second has `tlast_in`=1.
   - Response: one beat `data_out` bytes 00..1F, `tkeep_out`=FFFFFFFF, `tlast_out`=1, one cycle after the second accept.
2. **Overflow into FLUSH.**
   - Stimulus: a 24-byte beat, then a 24-byte beat with `tlast_in`=1.
   - Response: a full beat with `tlast_out`=0; then a beat with `tkeep_out`=0000FFFF carrying the last 16 bytes and `tlast_out`=1; `tready_out`=0 for exactly one cycle.
3. **Full-beat passthrough.**
   - Stimulus: 4 beats with `tkeep_in`=FFFFFFFF, the last with `tlast_in`=1, `tready_in`=1.
   - Response: identical beats out, one per cycle, 1-cycle latency, `tlast_out` on beat 4.
4. **Backpressure.**
   - Stimulus: `tready_in`=0 for 3 cycles while `tvalid_out`=1.
   - Response: `data_out`, `tkeep_out` and `tlast_out` stable and `tready_out`=0; after release, no byte is lost or duplicated (scoreboard byte-stream compare).
5. **Packet isolation and zero-length last.**
   - Stimulus: a 5-byte packet (`tkeep_in`=1F, `tlast_in`=1) immediately followed by a 0-byte beat with `tlast_in`=1.
   - Response: beat `tkeep_out`=0000001F with `tlast_out`=1, then beat `tkeep_out`=0 with `tlast_out`=1.
6. **Reset mid-packet.**
   - Stimulus: hold r=20, then pulse `reset` low for 2 cycles.
   - Response: all outputs 0 during reset; the next 32-byte last beat appears unmodified, with no stale residual bytes.
